// File: rtl/board_pkg.sv
// Board-level constants for the DE1-SoC switch conditioning path.
// Shared by the conditioner and its per-bit debouncer.
package board_pkg;

  localparam int SW_WIDTH    = 10;
  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  function automatic int ms_to_cycles(input int hz, input int ms);
    return (hz / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEFAULT =
    ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter,
// stable level register and registered rise/fall strobes.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic system1000,
  input  logic system1000_rstn,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   differ;
  logic [CW-1:0]          cnt;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign differ = sync != stable;
  assign accept = differ && (cnt == LAST);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any cycle of agreement restarts the count from zero
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= accept && sync;
      fall <= accept && !sync;
      if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        stable <= sync;
      end
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Slide-switch conditioner feeding clash_top SW: per-bit
// sync + debounce, with rise/fall and any-change strobes.
module sw_conditioner
  import board_pkg::*;
#(
  parameter int N_BITS          = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [N_BITS-1:0] sw_raw,
  output logic [N_BITS-1:0] sw_out,
  output logic [N_BITS-1:0] sw_rise,
  output logic [N_BITS-1:0] sw_fall,
  output logic              sw_changed
);

  logic [N_BITS-1:0] accept;

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .system1000     (system1000),
      .system1000_rstn(system1000_rstn),
      .raw            (sw_raw[i]),
      .stable         (sw_out[i]),
      .rise           (sw_rise[i]),
      .fall           (sw_fall[i]),
      .accept         (accept[i])
    );
  end

  // Registered from the same accept terms so it aligns with the strobes
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |accept;
    end
  end

endmodule
